// File: rtl/ads1299_frame_reader.sv
// ADS1299 RDATAC frame reader: SPI master, status capture, sign-extended channel beats.
// Optional STATUS_CHECK_EN: validate status[23:20]==4'b1100 and burst buffered channels after CS rises.
module ads1299_frame_reader #(
  parameter int CLK_DIV = 4,
  parameter int N_CH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        drdy_n,
  input  logic        spi_dout,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic [31:0] data,
  output logic        data_valid,
  output logic [2:0]  data_ch,
  output logic [23:0] status,
  output logic        overrun,
  output logic        frame_error
);
  localparam int TOTAL_BITS = 24 * (N_CH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [4:0]    wbit_q, wbit_d;
  logic [3:0]    word_q, word_d;
  logic [22:0]   sh_q, sh_d;
  logic [23:0]   stat_buf_q, stat_buf_d, status_q, status_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [2:0]    ch_q, ch_d;
  logic          overrun_q, overrun_d;
  logic          drdy_m_q, drdy_s_q, drdy_p_q, dout_m_q, dout_s_q;
  logic          drdy_evt, div_last;
  logic [23:0]   word_w;
  logic [2:0]    word_ch;

`ifdef STATUS_CHECK_EN
  logic [23:0]   buf_q [8];
  logic [23:0]   buf_d [8];
  logic          emit_q, emit_d, ferr_q, ferr_d;
  logic [2:0]    eidx_q, eidx_d;
`endif

  function automatic logic [31:0] sext24(input logic [23:0] w);
    return {{8{w[23]}}, w};
  endfunction

  assign drdy_evt = drdy_p_q & ~drdy_s_q;
  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign word_w   = {sh_q, dout_s_q};
  assign word_ch  = 3'(word_q - 4'd1);

  // data_valid is a one-cycle strobe with no ready: the consumer must take every beat.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    bit_cnt_d  = bit_cnt_q;
    wbit_d     = wbit_q;
    word_d     = word_q;
    sh_d       = sh_q;
    stat_buf_d = stat_buf_q;
    status_d   = status_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ch_d       = ch_q;
    overrun_d  = drdy_evt && (state_q != IDLE);
`ifdef STATUS_CHECK_EN
    buf_d  = buf_q;
    emit_d = emit_q;
    eidx_d = eidx_q;
    ferr_d = 1'b0;
    if (emit_q) begin
      data_d  = sext24(buf_q[eidx_q]);
      ch_d    = eidx_q;
      valid_d = 1'b1;
      eidx_d  = eidx_q + 3'd1;
      if (eidx_q == 3'(N_CH - 1)) emit_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (drdy_evt && enable) begin
          state_d   = CS_SETUP;
          cs_n_d    = 1'b0;
          div_d     = '0;
          bit_cnt_d = '0;
          wbit_d    = '0;
          word_d    = '0;
        end
      end
      CS_SETUP: begin
        if (div_last) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Sample at the end of the high phase, then drop SCLK.
            sclk_d    = 1'b0;
            sh_d      = word_w[22:0];
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (wbit_q == 5'd23) begin
              wbit_d = '0;
              word_d = word_q + 4'd1;
              if (word_q == 4'd0) begin
                stat_buf_d = word_w;
              end else begin
`ifdef STATUS_CHECK_EN
                buf_d[word_ch] = word_w;
`else
                data_d  = sext24(word_w);
                ch_d    = word_ch;
                valid_d = 1'b1;
`endif
              end
            end else begin
              wbit_d = wbit_q + 5'd1;
            end
            if (bit_cnt_q == 8'(TOTAL_BITS - 1)) state_d = CS_HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (div_last) begin
          state_d  = IDLE;
          cs_n_d   = 1'b1;
          div_d    = '0;
          status_d = stat_buf_q;
`ifdef STATUS_CHECK_EN
          if (stat_buf_q[23:20] == 4'b1100) begin
            data_d  = sext24(buf_q[0]);
            ch_d    = 3'd0;
            valid_d = 1'b1;
            emit_d  = (N_CH > 1);
            eidx_d  = 3'd1;
          end else begin
            ferr_d = 1'b1;
          end
`endif
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      word_q     <= '0;
      sh_q       <= '0;
      stat_buf_q <= '0;
      status_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      overrun_q  <= 1'b0;
      drdy_m_q   <= 1'b1;
      drdy_s_q   <= 1'b1;
      drdy_p_q   <= 1'b1;
      dout_m_q   <= 1'b0;
      dout_s_q   <= 1'b0;
`ifdef STATUS_CHECK_EN
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      emit_q <= 1'b0;
      eidx_q <= '0;
      ferr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      bit_cnt_q  <= bit_cnt_d;
      wbit_q     <= wbit_d;
      word_q     <= word_d;
      sh_q       <= sh_d;
      stat_buf_q <= stat_buf_d;
      status_q   <= status_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ch_q       <= ch_d;
      overrun_q  <= overrun_d;
      drdy_m_q   <= drdy_n;
      drdy_s_q   <= drdy_m_q;
      drdy_p_q   <= drdy_s_q;
      dout_m_q   <= spi_dout;
      dout_s_q   <= dout_m_q;
`ifdef STATUS_CHECK_EN
      buf_q  <= buf_d;
      emit_q <= emit_d;
      eidx_q <= eidx_d;
      ferr_q <= ferr_d;
`endif
    end
  end

  assign spi_sclk   = sclk_q;
  assign spi_cs_n   = cs_n_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign data_ch    = ch_q;
  assign status     = status_q;
  assign overrun    = overrun_q;
`ifdef STATUS_CHECK_EN
  assign frame_error = ferr_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_ads1299_frame_reader.sv
// Bench for ads1299_frame_reader: ADS1299 DOUT model, randomized frames, queue scoreboard.
module tb_ads1299_frame_reader;
  localparam int CLK_DIV = 4;
  localparam int N_CH    = 8;
  localparam int NBITS   = 24 * (N_CH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n, enable, drdy_n;
  logic spi_dout = 1'b0;
  logic spi_sclk, spi_cs_n, data_valid, overrun, frame_error;
  logic [31:0] data;
  logic [2:0]  data_ch;
  logic [23:0] status;

  always #10 clk = ~clk;

  ads1299_frame_reader #(.CLK_DIV(CLK_DIV), .N_CH(N_CH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .drdy_n(drdy_n),
    .spi_dout(spi_dout), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .data(data), .data_valid(data_valid), .data_ch(data_ch),
    .status(status), .overrun(overrun), .frame_error(frame_error)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0, n_fail = 0;
  logic [34:0] exp_q[$];
  logic [23:0] stat_q[$];
  logic [34:0] e;
  logic [23:0] es;
  int exp_ovr = 0, exp_ferr = 0, exp_falls = 0;
  int cyc = 0, cs_falls = 0, rises = 0, fall_cyc = 0, last_rise = 0, last_fall = 0, last_beat = 0;
  int ovr_cycles = 0, ferr_cycles = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] bfm_words [9];

  function automatic logic [31:0] sext_model(input logic [23:0] w);
    int v = int'(w);
    if (v >= 'h800000) v = v - 'h1000000;
    return 32'(v);
  endfunction

  function automatic logic bfm_bit(input int k);
    logic [23:0] w;
    if (k >= NBITS) return 1'b0;
    w = bfm_words[k / 24];
    return w[23 - (k % 24)];
  endfunction

  function automatic void push_frame();
    stat_q.push_back(bfm_words[0]);
`ifdef STATUS_CHECK_EN
    if (bfm_words[0][23:20] != 4'hC) begin
      exp_ferr++;
      return;
    end
`endif
    for (int c = 0; c < N_CH; c++) exp_q.push_back({3'(c), sext_model(bfm_words[c + 1])});
  endfunction

  // ADS1299 DOUT: first bit valid at CS fall, next bit after each SCLK fall.
  logic bfm_active = 1'b0;
  int   bfm_idx = 0;
  always @(negedge spi_cs_n or posedge spi_cs_n or negedge spi_sclk) begin
    if (spi_cs_n !== 1'b0) begin
      bfm_active = 1'b0;
    end else if (!bfm_active) begin
      bfm_active = 1'b1;
      bfm_idx = 0;
      spi_dout = bfm_bit(0);
    end else begin
      bfm_idx++;
      spi_dout = bfm_bit(bfm_idx);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (!spi_cs_n && cs_prev) begin
        cs_falls++;
        fall_cyc = cyc;
        rises = 0;
      end
      if (spi_sclk && !sclk_prev && !spi_cs_n) begin
        if (rises == 0) check("cs_setup", cyc - fall_cyc, CLK_DIV);
        else check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
        rises++;
        last_rise = cyc;
      end
      if (!spi_sclk && sclk_prev) last_fall = cyc;
      if (spi_cs_n && !cs_prev) begin
        check("sclk_count", rises, NBITS);
        check("cs_hold", cyc - last_fall, CLK_DIV);
        if (stat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL status_unexpected: frame ended with status %h, none required", status);
        end else begin
          es = stat_q.pop_front();
          check("status", 32'(status), 32'(es));
        end
      end
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got ch %0d data %h, none required", data_ch, data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", data, e[31:0]);
          check("beat_ch", 32'(data_ch), 32'(e[34:32]));
`ifdef STATUS_CHECK_EN
          if (data_ch == 3'd0) check("beat_start", 32'(spi_cs_n & ~cs_prev), 1);
          else check("beat_gap", cyc - last_beat, 1);
`else
          if (data_ch != 3'd0) check("beat_gap", cyc - last_beat, 48 * CLK_DIV);
`endif
          last_beat = cyc;
        end
      end
      if (overrun) ovr_cycles++;
      if (frame_error) ferr_cycles++;
    end
    cs_prev = spi_cs_n;
    sclk_prev = spi_sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic drdy_pulse();
    @(posedge clk); #1 drdy_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 drdy_n = 1'b1;
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string what);
    int n = 0;
    while (spi_cs_n !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(what, 32'(spi_cs_n), 32'(lvl));
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("bit_progress", 32'(rises >= target), 1);
  endtask

  task automatic start_frame(input bit model);
    if (model) push_frame();
    exp_falls++;
    drdy_pulse();
    wait_cs(1'b0, 20, "cs_fall_timeout");
  endtask

  task automatic finish_frame();
    wait_cs(1'b1, 3000, "cs_rise_timeout");
    repeat (20) @(negedge clk);
  endtask

  task automatic random_words(input bit good_status);
    for (int i = 0; i < 9; i++) bfm_words[i] = 24'($urandom);
    if ($urandom_range(0, 1) == 1) bfm_words[$urandom_range(1, 8)] = 24'h800000;
    if (good_status) bfm_words[0][23:20] = 4'hC;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    drdy_n  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 1);
    check("rst_sclk", 32'(spi_sclk), 0);
    check("rst_data", data, 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_ch", 32'(data_ch), 0);
    check("rst_status", 32'(status), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_ferr", 32'(frame_error), 0);
    @(posedge clk); #1 reset_n = 1'b1; enable = 1'b1;
    repeat (5) @(posedge clk);

    // Reference frame with full-scale positive and negative channels.
    bfm_words[0] = 24'hC00000;
    bfm_words[1] = 24'h7FFFFF;
    bfm_words[2] = 24'h800000;
    for (int i = 3; i < 9; i++) bfm_words[i] = 24'h000001;
    start_frame(1'b1);
    finish_frame();

    for (int f = 0; f < 4; f++) begin
      random_words(f != 3);
      start_frame(1'b1);
      finish_frame();
    end

    // Second DRDY mid-frame: overrun pulse, frame unaffected, nothing queued.
    random_words(1'b1);
    start_frame(1'b1);
    wait_rises(100);
    exp_ovr++;
    drdy_pulse();
    finish_frame();
    repeat (200) @(negedge clk);
    check("no_extra_frame", cs_falls, exp_falls);

    // Synchronous reset mid-frame discards the partial frame.
    random_words(1'b1);
    start_frame(1'b0);
`ifndef STATUS_CHECK_EN
    exp_q.push_back({3'd0, sext_model(bfm_words[1])});
`endif
    wait_rises(50);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs_n", 32'(spi_cs_n), 1);
    check("midrst_sclk", 32'(spi_sclk), 0);
    check("midrst_valid", 32'(data_valid), 0);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    random_words(1'b1);
    start_frame(1'b1);
    finish_frame();

    // DRDY with enable low is ignored; re-enabled DRDY is served.
    @(posedge clk); #1 enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drdy_pulse();
      repeat (30) @(posedge clk);
    end
    @(negedge clk);
    check("enable_gate", cs_falls, exp_falls);
    check("enable_gate_cs", 32'(spi_cs_n), 1);
    @(posedge clk); #1 enable = 1'b1;
    random_words(1'b1);
    start_frame(1'b1);
    finish_frame();

    // Enable dropped mid-frame: the frame still completes.
    random_words(1'b1);
    start_frame(1'b1);
    @(posedge clk); #1 enable = 1'b0;
    finish_frame();
    @(posedge clk); #1 enable = 1'b1;

    // Status failing the header pattern, then a passing one.
    for (int i = 0; i < 9; i++) bfm_words[i] = 24'($urandom);
    bfm_words[0] = 24'h000000;
    start_frame(1'b1);
    finish_frame();
    bfm_words[0] = 24'hC00000;
    start_frame(1'b1);
    finish_frame();

    repeat (50) @(negedge clk);
    check("beats_outstanding", exp_q.size(), 0);
    check("status_outstanding", stat_q.size(), 0);
    check("overrun_cycles", ovr_cycles, exp_ovr);
    check("frame_error_cycles", ferr_cycles, exp_ferr);
    check("frames_started", cs_falls, exp_falls);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait loop misbehaves.
  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation ran past 5 ms");
    $fatal(1, "timeout");
  end

endmodule
